// File: rtl/bitfusion_pkg.sv
// bitfusion_pkg: weight-mode encodings and beat-count helpers shared by the
// input sorter and its crumb expander.
package bitfusion_pkg;

    localparam int CRUMB_W = 2;

    typedef enum logic [1:0] {
        MODE_8B = 2'b00,
        MODE_4B = 2'b01,
        MODE_2B = 2'b10
    } mode_e;

    // Encoding 11 is reserved and behaves as 8-bit.
    function automatic mode_e norm_mode(input logic [1:0] m);
        return (m == 2'b11) ? MODE_8B : mode_e'(m);
    endfunction

    function automatic logic [2:0] beats_of(input mode_e mode);
        return (mode == MODE_4B) ? 3'd2 : (mode == MODE_2B) ? 3'd4 : 3'd1;
    endfunction

endpackage

// File: rtl/bitfusion_crumb_expand.sv
// bitfusion_crumb_expand: replicates the 2-bit crumbs of a right-aligned chunk
// so each beat matches the weight bitwidth of the BitBrick array.
module bitfusion_crumb_expand
    import bitfusion_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] chunk_i,
    input  mode_e             mode_i,
    output logic [DATA_W-1:0] beat_o
);

    logic [DATA_W-1:0] exp4, exp2;

    // 4-bit: each byte becomes {c3,c3,c1,c1,c2,c2,c0,c0}.
    for (genvar i = 0; i < DATA_W / 16; i++) begin : g_exp4
        logic [7:0] b;
        assign b = chunk_i[8*i +: 8];
        assign exp4[16*i +: 16] = {b[7:6], b[7:6], b[3:2], b[3:2], b[5:4], b[5:4], b[1:0], b[1:0]};
    end

    for (genvar j = 0; j < DATA_W / 8; j++) begin : g_exp2
        assign exp2[8*j +: 8] = {4{chunk_i[CRUMB_W*j +: CRUMB_W]}};
    end

    assign beat_o = (mode_i == MODE_4B) ? exp4 : (mode_i == MODE_2B) ? exp2 : chunk_i;

endmodule

// File: rtl/bitfusion_input_sorter.sv
// bitfusion_input_sorter: splits each buffer word into 1, 2 or 4 crumb-replicated
// beats with valid/ready flow control and a mode latched per word.
module bitfusion_input_sorter
    import bitfusion_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        weight_bitwidth,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_beat,
    output logic              out_last
);

    typedef enum logic {EMPTY, BUSY} state_e;

    state_e            state_q, state_d;
    mode_e             mode_q, mode_d, exp_mode;
    logic [DATA_W-1:0] hold_q, hold_d, data_q, data_d, chunk, beat;
    logic [1:0]        beat_q, beat_d, beat_nx;
    logic              in_hs, out_hs;

    assign out_valid = (state_q == BUSY);
    assign out_data  = data_q;
    assign out_beat  = beat_q;
    assign out_last  = ({1'b0, beat_q} == beats_of(mode_q) - 3'd1);
    assign in_ready  = !out_valid | (out_ready & out_last);
    assign in_hs     = in_valid & in_ready;
    assign out_hs    = out_valid & out_ready;
    assign beat_nx   = beat_q + 2'd1;

    // A new word feeds its beat 0 straight from in_data; later beats are the
    // held word shifted down to the next chunk offset.
    assign chunk = in_hs ? in_data
                 : (mode_q == MODE_4B || beat_nx == 2'd2) ? hold_q >> (DATA_W / 2)
                 : (beat_nx == 2'd3) ? hold_q >> (3 * DATA_W / 4)
                 : hold_q >> (DATA_W / 4);
    assign exp_mode = in_hs ? norm_mode(weight_bitwidth) : mode_q;

    bitfusion_crumb_expand #(.DATA_W(DATA_W)) u_expand (
        .chunk_i (chunk),
        .mode_i  (exp_mode),
        .beat_o  (beat)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        hold_d  = hold_q;
        data_d  = data_q;
        beat_d  = beat_q;
        if (in_hs) begin
            state_d = BUSY;
            mode_d  = exp_mode;
            hold_d  = in_data;
            data_d  = beat;
            beat_d  = 2'd0;
        end else if (out_hs) begin
            state_d = out_last ? EMPTY : BUSY;
            data_d  = out_last ? data_q : beat;
            beat_d  = out_last ? 2'd0 : beat_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            mode_q  <= MODE_8B;
            hold_q  <= '0;
            data_q  <= '0;
            beat_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            hold_q  <= hold_d;
            data_q  <= data_d;
            beat_q  <= beat_d;
        end
    end

endmodule

// File: tb/tb_bitfusion_input_sorter.sv
// tb_bitfusion_input_sorter: scoreboard bench; the stimulus side pushes the beats
// each accepted word must produce, the monitor pops and compares them.
module tb_bitfusion_input_sorter;

    typedef struct {
        logic [31:0] d;
        logic [1:0]  b;
        logic        l;
    } exp_t;

    logic        clk = 0, reset = 1, in_valid = 0, out_ready = 0;
    logic [1:0]  weight_bitwidth = 2'd0;
    logic [31:0] in_data = 32'd0;
    logic        in_ready, out_valid, out_last;
    logic [31:0] out_data;
    logic [1:0]  out_beat;
    exp_t        q[$];
    int          checks = 0, failures = 0;
    bit          acc;

    always #5 clk = ~clk;

    bitfusion_input_sorter #(.DATA_W(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .weight_bitwidth (weight_bitwidth),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_data         (in_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .out_beat        (out_beat),
        .out_last        (out_last)
    );

    task automatic chk(string n, logic [31:0] a, logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", n, a, e, $time);
        end
    endtask

    // Crumb value c replicated k times equals c times 0b0101.. of matching width.
    function automatic logic [31:0] expand(int nb, logic [31:0] c);
        int r, by, cr;
        r = 0;
        if (nb == 1) return c;
        if (nb == 2)
            for (int i = 0; i < 2; i++) begin
                by = int'((c >> (8 * i)) & 32'hFF);
                r |= ((((by >> 6) & 3) * 5) << 12 | (((by >> 2) & 3) * 5) << 8
                     | (((by >> 4) & 3) * 5) << 4 | (by & 3) * 5) << (16 * i);
            end
        else
            for (int j = 0; j < 4; j++) begin
                cr = int'((c >> (2 * j)) & 32'h3);
                r |= (cr * 85) << (8 * j);
            end
        return 32'(r);
    endfunction

    task automatic push_word(logic [1:0] wb, logic [31:0] w);
        int nb;
        nb = (wb == 2'd1) ? 2 : (wb == 2'd2) ? 4 : 1;
        for (int k = 0; k < nb; k++)
            q.push_back('{d: expand(nb, w >> (k * (32 / nb))), b: 2'(k), l: (k == nb - 1)});
    endtask

    task automatic step(bit r, bit iv, logic [31:0] d, logic [1:0] wb, bit ordy);
        @(posedge clk);
        #1;
        reset = r;
        in_valid = iv;
        in_data = d;
        weight_bitwidth = wb;
        out_ready = ordy;
        @(negedge clk);
        acc = 0;
        if (r) q.delete();
        else if (iv && in_ready) begin
            push_word(wb, d);
            acc = 1;
        end
    endtask

    task automatic present(logic [1:0] wb, logic [31:0] d);
        int n;
        n = 0;
        do begin
            step(0, 1, d, wb, 1);
            n++;
        end while (!acc && n < 20);
        checks++;
        if (!acc) begin
            failures++;
            $display("FAIL accept_timeout got=0 exp=1 data=%0h", d);
        end
    endtask

    initial begin : monitor
        logic r;
        forever begin
            @(posedge clk);
            r = reset;
            #3;
            if (r) begin
                chk("rst_out_valid", 32'(out_valid), 32'd0);
                chk("rst_out_data", out_data, 32'd0);
                chk("rst_out_beat", 32'(out_beat), 32'd0);
                chk("rst_in_ready", 32'(in_ready), 32'd1);
            end else begin
                chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
                chk("in_ready", 32'(in_ready), 32'((q.size() == 0) ? 1'b1 : (out_ready && q[0].l)));
                if (out_valid && q.size() != 0) begin
                    chk("out_data", out_data, q[0].d);
                    chk("out_beat", 32'(out_beat), 32'(q[0].b));
                    chk("out_last", 32'(out_last), 32'(q[0].l));
                    if (out_ready) void'(q.pop_front());
                end
            end
        end
    end

    initial begin : stimulus
        int n;
        bit pat[11] = '{0, 0, 1, 1, 0, 0, 1, 0, 1, 1, 1};
        repeat (3) step(1, 0, 0, 0, 0);
        present(2'd2, 32'h0000_00E4);
        repeat (4) step(0, 0, 0, 2'd2, 1);
        present(2'd1, 32'h0000_E4E4);
        repeat (2) step(0, 0, 0, 2'd1, 1);
        present(2'd0, 32'h1122_3344);
        present(2'd0, 32'hDEAD_BEEF);
        step(0, 0, 0, 2'd0, 1);
        present(2'd2, 32'h9C3A_71E5);
        foreach (pat[i]) step(0, 0, 0, 2'd2, pat[i]);
        repeat (3) step(0, 0, 0, 2'd2, 1);
        present(2'd2, 32'hC6E4_1B27);
        step(0, 0, 0, 2'd2, 1);
        step(0, 0, 0, 2'd0, 1);
        step(0, 0, 0, 2'd0, 1);
        present(2'd0, 32'hCAFE_F00D);
        step(0, 0, 0, 2'd0, 1);
        present(2'd2, 32'h5A5A_0FF0);
        step(0, 0, 0, 2'd2, 1);
        step(0, 0, 0, 2'd2, 1);
        step(1, 0, 0, 2'd2, 0);
        repeat (3) step(0, 0, 0, 2'd2, 1);
        present(2'd3, 32'h0123_4567);
        step(0, 0, 0, 2'd1, 1);
        repeat (800)
            step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 6, $urandom,
                 2'($urandom_range(0, 3)), $urandom_range(0, 9) < 7);
        n = 0;
        while (q.size() != 0 && n < 20) begin
            step(0, 0, 0, 2'd0, 1);
            n++;
        end
        chk("drain_empty", 32'(q.size()), 32'd0);
        step(0, 0, 0, 2'd0, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
